// File: rtl/shift_add_multiplier.sv
// Sequential shift-and-add unsigned multiplier: one partial product per cycle, WIDTH cycles per multiply.
// Latency WIDTH cycles from accepted start to the load strobe; start is ignored unless idle.
module shift_add_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 load,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [2*WIDTH-1:0]   r_acc;
  logic [CW-1:0]        r_cnt;
  logic [2*WIDTH-1:0]   r_product;
  logic [2*WIDTH-1:0]   w_sum;
  logic                 w_last;

  assign w_sum   = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_last  = (r_cnt == CW'(WIDTH - 1));
  assign product = r_product;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    load = 1'b0;
    case (r_state)
      S_RUN:   busy = 1'b1;
      S_DONE:  load = 1'b1;
      default: ;
    endcase
  end

  // The final iteration's sum goes straight into product so the strobe and data line up in DONE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mcand  <= {{WIDTH{1'b0}}, a};
            r_mplier <= b;
            r_acc    <= '0;
            r_cnt    <= '0;
          end
        end
        S_RUN: begin
          r_acc    <= w_sum;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CW'(1);
          if (w_last) r_product <= w_sum;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Scoreboard bench for shift_add_multiplier: directed operands, expected products queued at issue.
module tb_shift_add_multiplier;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        busy;
  logic        load;
  logic [31:0] product;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  shift_add_multiplier #(.WIDTH(16)) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .load    (load),
    .product (product)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every load strobe must match the oldest queued expectation.
  always @(negedge clock) begin
    if (reset && load) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL spurious_load: got product %0h expected no strobe", product);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (product !== e) begin
          errors++;
          $display("FAIL product: got %0h expected %0h", product, e);
        end
      end
    end
  end

  // One multiply; optionally pulse start with other operands at sample index glitch_j.
  task automatic run_one(input logic [15:0] ia, input logic [15:0] ib,
                         input logic [31:0] iexp, input int glitch_j);
    int busy_cnt;
    int load_at;
    int load_cnt;
    @(negedge clock);
    a = ia; b = ib; start = 1'b1;
    exp_q.push_back(iexp);
    @(negedge clock);
    start = 1'b0;
    busy_cnt = 0; load_at = -1; load_cnt = 0;
    for (int j = 0; j < 20; j++) begin
      if (busy) busy_cnt++;
      if (load) begin
        load_cnt++;
        if (load_at < 0) load_at = j;
      end
      if (j == glitch_j) begin
        a = 16'd7; b = 16'd7; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clock);
    end
    chk("busy_cycles", busy_cnt, 16);
    chk("load_latency", load_at, 16);
    chk("load_count", load_cnt, 1);
    chk("product_held", product, iexp);
  endtask

  initial begin
    int t_load[$];
    int cyc;
    #1;
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_load", {31'd0, load}, 0);
    chk("rst_product", product, 0);
    #20;
    @(negedge clock);
    reset = 1'b1;

    run_one(16'd5, 16'd11, 32'd55, -1);
    run_one(16'hFFFF, 16'hFFFF, 32'hFFFE0001, -1);
    run_one(16'd0, 16'h1234, 32'd0, -1);
    run_one(16'd3, 16'd5, 32'd15, 5);

    // start held high: three back-to-back multiplies
    repeat (3) exp_q.push_back(32'd10);
    @(negedge clock);
    a = 16'd2; b = 16'd5; start = 1'b1;
    cyc = 0;
    while (t_load.size() < 3 && cyc < 100) begin
      @(negedge clock);
      cyc++;
      if (load) t_load.push_back(cyc);
    end
    start = 1'b0;
    chk("held_load_count", t_load.size(), 3);
    if (t_load.size() == 3) begin
      chk("held_spacing1", t_load[1] - t_load[0], 18);
      chk("held_spacing2", t_load[2] - t_load[1], 18);
    end
    chk("held_product", product, 32'd10);
    repeat (4) @(negedge clock);

    // reset at RUN iteration 8
    @(negedge clock);
    a = 16'd10; b = 16'd10; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (8) @(negedge clock);
    chk("pre_reset_busy", {31'd0, busy}, 1);
    reset = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 0);
    chk("arst_load", {31'd0, load}, 0);
    chk("arst_product", product, 0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    cyc = 0;
    for (int j = 0; j < 20; j++) begin
      if (load) cyc++;
      @(negedge clock);
    end
    chk("no_load_after_reset", cyc, 0);
    run_one(16'd6, 16'd7, 32'd42, -1);

    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_add_multiplier.md
Name: shift_add_multiplier

Overview:
- Sequential shift-and-add unsigned multiplier; upstream producer for the team's 32-bit load-enabled register.
- Computes a WIDTH x WIDTH unsigned product over WIDTH iterations.
- Presents the 2*WIDTH-bit result on `product`. `load` is a one-cycle strobe wired directly to the register's select/load input, so the result is captured exactly once per multiply.

Parameters:
- WIDTH, 16, operand width in bits. Product width is 2*WIDTH (32 at default, matching the register).

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately
- start  input  1  request a multiply; sampled on rising edge, accepted only in IDLE
- a  input  WIDTH  multiplicand; latched when start is accepted
- b  input  WIDTH  multiplier; latched when start is accepted
- busy  output  1  high while a multiply is in progress (RUN state)
- load  output  1  one-cycle strobe, high in DONE; drives register select
- product  output  2*WIDTH  result register; valid whenever load=1, held otherwise

Behaviour:
- Reset (reset=0, async): state=IDLE; busy=0; load=0; product=0; internal accumulator, operand copies and iteration counter = 0. Holds while reset=0.
- States: IDLE, RUN, DONE. Encoded internally; no output depends on encoding.
- IDLE:
  - start=1 at edge k: latch a into a 2*WIDTH-bit multiplicand register, zero-extended.
  - Latch b into a WIDTH-bit multiplier shift register.
  - Clear accumulator; counter=0; go to RUN.
  - start=0: stay in IDLE.
- RUN, one iteration per edge, edges k+1 .. k+WIDTH:
  - if multiplier[0]=1: accumulator <= accumulator + multiplicand, 2*WIDTH-bit add.
  - Overflow is impossible by construction; there is no carry-out.
  - multiplicand <= multiplicand << 1; multiplier <= multiplier >> 1; counter <= counter+1.
  - On the edge where counter reaches WIDTH-1, i.e. edge k+WIDTH:
    - write the final sum into `product`;
    - go to DONE.
- DONE:
  - load=1 for exactly one cycle, between edge k+WIDTH and edge k+WIDTH+1.
  - Next edge unconditionally returns to IDLE.
- Latency: start accepted at edge k, load high after edge k+WIDTH (16 cycles at default). Throughput is one multiply per WIDTH+2 cycles.
- busy: 1 exactly in RUN; 0 in IDLE and DONE.
- start while in RUN or DONE: ignored. Operands are not re-latched and the in-flight result is unaffected.
- start held continuously high: a new multiply is accepted on the first edge back in IDLE. This gives back-to-back operations with one idle cycle between a DONE and the next RUN.
- product: updated only on the completing edge. It holds its previous value through IDLE and RUN, so it is stable between strobes.
- a, b changing during RUN: no effect.
- Zero operands: no early termination. The full WIDTH iterations run and load still pulses.
- Reset mid-RUN or mid-DONE: abort immediately.
  - If load was high, it drops at once.
  - product clears to 0.
  - No load pulse follows release.
  - After release, the first start in IDLE behaves normally.
- Counter width: $clog2(WIDTH) bits minimum. No other arithmetic width extension is permitted.

Test Plan:
- Reset then a=5, b=11, start one cycle:
  - busy=1 for 16 cycles;
  - load=1 for exactly 1 cycle, 16 edges after acceptance;
  - product=32'd55, held after load drops.
- a=16'hFFFF, b=16'hFFFF -> product=32'hFFFE0001 at load; no spurious load pulses.
- a=0, b=16'h1234 -> full 16-cycle latency; product=0; load pulses once.
- Start a=3, b=5; pulse start with a=7, b=7 mid-RUN:
  - product=32'd15;
  - only one load pulse;
  - busy pattern unchanged.
- start held high with a=2, b=5 throughout:
  - consecutive load pulses spaced 18 cycles apart;
  - product=32'd10 each time.
- Start a=10, b=10; drive reset=0 for 3 cycles at RUN iteration 8:
  - outputs go to 0 immediately, with no clock required;
  - no load pulse;
  - a subsequent start with a=6, b=7 gives product=32'd42.
